johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_decoder_if.sv | 20 ++
 rtl/johnson_decoder.sv | 94 +++++++++
 tb/tb_johnson_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: sample/control inputs and decoded outputs of the Johnson decoder
interface johnson_decoder_if;
    logic [3:0] code_i;
    logic       valid_i;
    logic       clr_i;
    logic [2:0] index_o;
    logic       valid_o;
    logic       dir_o;
    logic       locked_o;
    logic       err_o;
    logic [7:0] pos_o;
    modport master (
        output code_i, valid_i, clr_i,
        input  index_o, valid_o, dir_o, locked_o, err_o, pos_o
    );
    modport slave (
        input  code_i, valid_i, clr_i,
        output index_o, valid_o, dir_o, locked_o, err_o, pos_o
    );
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a sampled 4-bit Johnson code, tracks direction, lock and relative position
module johnson_decoder #(
    parameter int LOCK_CNT = 3
) (
    input logic clk_i,
    input logic rst_i,
    johnson_decoder_if.slave bus
);
    localparam logic [2:0] LC = 3'(LOCK_CNT);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, ERROR} state_t;
    state_t     state, state_n;
    logic [2:0] index, index_n, run, run_n, run_step, idx;
    logic [7:0] pos, pos_n;
    logic       dir, dir_n, valid, valid_n, legal, fwd, rev;
    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (bus.code_i)
            4'b1111: idx = 3'd0;
            4'b0111: idx = 3'd1;
            4'b0011: idx = 3'd2;
            4'b0001: idx = 3'd3;
            4'b0000: idx = 3'd4;
            4'b1000: idx = 3'd5;
            4'b1100: idx = 3'd6;
            4'b1110: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end
    assign fwd = idx == index + 3'd1;
    assign rev = idx == index - 3'd1;
    // a direction change restarts the run at 1 (this step counts), a fresh run just counts up
    assign run_step = (run == 3'd0 || fwd == dir) ? ((run == LC) ? run : run + 3'd1) : 3'd1;
    always_comb begin
        state_n = state;
        index_n = index;
        dir_n   = dir;
        pos_n   = pos;
        run_n   = run;
        valid_n = 1'b0;
        if (bus.clr_i) begin
            state_n = IDLE;
            pos_n   = 8'd0;
            run_n   = 3'd0;
        end else if (bus.valid_i && state != ERROR) begin
            if (!legal) begin
                state_n = ERROR;
            end else if (state == IDLE) begin
                index_n = idx;
                valid_n = 1'b1;
                run_n   = 3'd0;
                state_n = ACQUIRE;
            end else if (idx == index) begin
                valid_n = 1'b1;
            end else if (fwd || rev) begin
                index_n = idx;
                valid_n = 1'b1;
                dir_n   = fwd;
                pos_n   = fwd ? pos + 8'd1 : pos - 8'd1;
                run_n   = run_step;
                state_n = (run_step == LC) ? LOCKED : state;
            end else if (state == LOCKED) begin
                state_n = ERROR;
            end else begin
                index_n = idx;
                valid_n = 1'b1;
                run_n   = 3'd0;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            index <= 3'd0;
            dir   <= 1'b1;
            pos   <= 8'd0;
            run   <= 3'd0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            index <= index_n;
            dir   <= dir_n;
            pos   <= pos_n;
            run   <= run_n;
            valid <= valid_n;
        end
    end
    assign bus.index_o  = index;
    assign bus.valid_o  = valid;
    assign bus.dir_o    = dir;
    assign bus.pos_o    = pos;
    assign bus.locked_o = state == LOCKED;
    assign bus.err_o    = state == ERROR;
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed and randomized checks of johnson_decoder against a behavioural model
module tb_johnson_decoder;
    localparam int LOCK = 3;
    localparam logic [14:0] RST_VEC = {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int total = 0;
    int bad = 0;
    johnson_decoder_if bus();
    johnson_decoder #(.LOCK_CNT(LOCK)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
    always #5 clk_i = ~clk_i;
    logic [3:0] codes [8] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000, 4'b1100, 4'b1110};
    logic [2:0] m_index;
    logic       m_valid, m_dir;
    logic [7:0] m_pos;
    int         m_state, m_run;
    wire [14:0] dut_vec = {bus.index_o, bus.valid_o, bus.dir_o, bus.locked_o, bus.err_o, bus.pos_o};
    function automatic logic [14:0] mvec();
        return {m_index, m_valid, m_dir, m_state == 2, m_state == 3, m_pos};
    endfunction
    function automatic int dec(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
        return -1;
    endfunction
    function automatic void model_reset();
        m_index = 3'd0; m_valid = 1'b0; m_dir = 1'b1; m_pos = 8'd0; m_state = 0; m_run = 0;
    endfunction
    // states: 0 idle, 1 acquire, 2 locked, 3 error; position kept as a plain modulo-256 counter
    function automatic void model(input logic [3:0] c, input logic v, input logic cl);
        int d, delta;
        logic f;
        m_valid = 1'b0;
        if (cl) begin
            m_state = 0; m_pos = 8'd0; m_run = 0;
        end else if (v && m_state != 3) begin
            d = dec(c);
            if (d < 0) m_state = 3;
            else if (m_state == 0) begin
                m_index = 3'(d); m_valid = 1'b1; m_run = 0; m_state = 1;
            end else begin
                delta = (d - int'(m_index) + 8) % 8;
                if (delta == 0) m_valid = 1'b1;
                else if (delta == 1 || delta == 7) begin
                    f = (delta == 1);
                    m_run = (m_run == 0 || f == m_dir) ? ((m_run + 1 > LOCK) ? LOCK : m_run + 1) : 1;
                    m_dir = f;
                    m_pos = f ? m_pos + 8'd1 : m_pos - 8'd1;
                    m_index = 3'(d);
                    m_valid = 1'b1;
                    if (m_run == LOCK) m_state = 2;
                end else if (m_state == 2) m_state = 3;
                else begin
                    m_index = 3'(d); m_valid = 1'b1; m_run = 0;
                end
            end
        end
    endfunction
    task automatic step(input logic [3:0] c, input logic v, input logic cl);
        @(negedge clk_i);
        bus.code_i = c; bus.valid_i = v; bus.clr_i = cl;
        @(posedge clk_i);
        #1;
        model(c, v, cl);
    endtask
    task automatic test_reset();
        bus.code_i = 4'b0000; bus.valid_i = 1'b0; bus.clr_i = 1'b0;
        model_reset();
        #12;
        total++; if (dut_vec !== RST_VEC) begin bad++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, RST_VEC); end
        @(negedge clk_i); rst_i = 1'b1;
        step(4'b0111, 1'b0, 1'b0);
        total++; if (dut_vec !== RST_VEC) begin bad++; $display("FAIL idle_hold got=%h exp=%h", dut_vec, RST_VEC); end
    endtask
    task automatic test_forward_lock();
        for (int i = 0; i < 5; i++) begin
            step(codes[i], 1'b1, 1'b0);
            total++; if (dut_vec !== mvec()) begin bad++; $display("FAIL fwd_model[%0d] got=%h exp=%h", i, dut_vec, mvec()); end
            total++; if (bus.index_o !== 3'(i) || bus.valid_o !== 1'b1) begin bad++; $display("FAIL fwd_index[%0d] got=%0d/%b exp=%0d/1", i, bus.index_o, bus.valid_o, i); end
            total++; if (bus.locked_o !== (i >= 3)) begin bad++; $display("FAIL fwd_locked[%0d] got=%b exp=%b", i, bus.locked_o, i >= 3); end
        end
        total++; if (bus.pos_o !== 8'd4 || bus.dir_o !== 1'b1) begin bad++; $display("FAIL fwd_pos got=%0d dir=%b exp=4 dir=1", bus.pos_o, bus.dir_o); end
    endtask
    task automatic test_reverse();
        step(4'b0001, 1'b1, 1'b0);
        total++; if (bus.dir_o !== 1'b0 || bus.locked_o !== 1'b1 || bus.pos_o !== 8'd3) begin bad++; $display("FAIL rev1 got dir=%b lk=%b pos=%0d exp 0 1 3", bus.dir_o, bus.locked_o, bus.pos_o); end
        step(4'b0011, 1'b1, 1'b0);
        total++; if (bus.dir_o !== 1'b0 || bus.locked_o !== 1'b1 || bus.pos_o !== 8'd2 || bus.index_o !== 3'd2) begin bad++; $display("FAIL rev2 got dir=%b lk=%b pos=%0d idx=%0d exp 0 1 2 2", bus.dir_o, bus.locked_o, bus.pos_o, bus.index_o); end
        step(4'b0001, 1'b0, 1'b0);
        total++; if (dut_vec !== mvec() || bus.valid_o !== 1'b0) begin bad++; $display("FAIL rev_hold got=%h exp=%h", dut_vec, mvec()); end
    endtask
    task automatic test_error();
        step(4'b0101, 1'b1, 1'b0);
        total++; if (bus.err_o !== 1'b1 || bus.locked_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.index_o !== 3'd2 || bus.pos_o !== 8'd2) begin bad++; $display("FAIL err_entry got=%h", dut_vec); end
        total++; if (dut_vec !== mvec()) begin bad++; $display("FAIL err_model got=%h exp=%h", dut_vec, mvec()); end
        step(4'b0111, 1'b1, 1'b0);
        total++; if (dut_vec !== {3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2}) begin bad++; $display("FAIL err_ignore got=%h exp=%h", dut_vec, {3'd2, 4'b0001, 8'd2}); end
        step(4'b0111, 1'b0, 1'b1);
        total++; if (bus.err_o !== 1'b0 || bus.pos_o !== 8'd0 || bus.locked_o !== 1'b0 || bus.valid_o !== 1'b0) begin bad++; $display("FAIL err_clear got=%h", dut_vec); end
    endtask
    task automatic test_skip();
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        total++; if (dut_vec !== {3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1}) begin bad++; $display("FAIL skip got=%h exp=%h", dut_vec, {3'd4, 4'b1100, 8'd1}); end
        step(4'b1000, 1'b1, 1'b0);
        step(4'b1100, 1'b1, 1'b0);
        total++; if (bus.locked_o !== 1'b0 || bus.pos_o !== 8'd3) begin bad++; $display("FAIL skip_restart got lk=%b pos=%0d exp 0 3", bus.locked_o, bus.pos_o); end
        step(4'b1110, 1'b1, 1'b0);
        total++; if (bus.locked_o !== 1'b1 || dut_vec !== mvec()) begin bad++; $display("FAIL skip_lock got=%h exp=%h", dut_vec, mvec()); end
    endtask
    task automatic test_async_reset();
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        model_reset();
        total++; if (dut_vec !== RST_VEC) begin bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec, RST_VEC); end
        @(negedge clk_i); rst_i = 1'b1;
        step(4'b1111, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b1);
        total++; if (bus.valid_o !== 1'b0 || bus.pos_o !== 8'd0 || bus.index_o !== 3'd0) begin bad++; $display("FAIL clr_priority got=%h", dut_vec); end
        step(4'b0111, 1'b1, 1'b0);
        total++; if (dut_vec !== {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin bad++; $display("FAIL post_clr_idle got=%h exp=%h", dut_vec, {3'd1, 4'b1100, 8'd0}); end
    endtask
    task automatic test_wrap();
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 135; i++) begin
            step(codes[i % 8], 1'b1, 1'b0);
            total++; if (dut_vec !== mvec()) begin bad++; $display("FAIL wrap_model[%0d] got=%h exp=%h", i, dut_vec, mvec()); end
            if (i == 127) begin
                total++; if (bus.pos_o !== 8'h7f) begin bad++; $display("FAIL wrap_127 got=%0d exp=127", $signed(bus.pos_o)); end
            end
            if (i == 128) begin
                total++; if (bus.pos_o !== 8'h80 || bus.index_o !== 3'd0) begin bad++; $display("FAIL wrap_m128 got=%0d idx=%0d exp=-128 idx=0", $signed(bus.pos_o), bus.index_o); end
            end
        end
    endtask
    task automatic test_random();
        logic fdir = 1'b1;
        logic [3:0] c;
        int r;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) fdir = ~fdir;
            if (r < 70) c = codes[(int'(m_index) + (r < 10 ? 0 : (fdir ? 1 : 7))) % 8];
            else if (r < 85) c = codes[$urandom_range(0, 7)];
            else c = 4'($urandom_range(0, 15));
            step(c, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
            total++; if (dut_vec !== mvec()) begin bad++; $display("FAIL random[%0d] code=%b got=%h exp=%h", n, c, dut_vec, mvec()); end
        end
    endtask
    initial begin
        test_reset();
        test_forward_lock();
        test_reverse();
        test_error();
        test_skip();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
